method_call_arbiter: RTL
========================

Name: method_call_arbiter

Overview:
- Shares one compiled method unit (req/busy/return call protocol, one argument word) between N_CLIENTS requesters.
- Grants callers round-robin, forwards the latched argument and issues the call.
- Tracks the callee's busy handshake and returns the result with a per-client done pulse.
- Provides a timeout so a hung callee cannot deadlock the system. Sits between test/application sequencers and a single shared method instance.

Parameters:
N_CLIENTS, 4, number of requesters (2..16)
ARG_W, 32, argument width
RET_W, 32, return value width
TIMEOUT, 10000, max cycles per call before abort (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cl_req  in  N_CLIENTS  per-client call request, level, held until that client's cl_done
cl_arg  in  N_CLIENTS*ARG_W  per-client argument, slice i = client i; stable while cl_req[i]=1
cl_done  out  N_CLIENTS  one-cycle completion pulse to granted client
cl_ret  out  RET_W  return value; valid in the cl_done cycle, held until next completion
cl_err  out  1  high in the cl_done cycle if the call timed out
m_req  out  1  call request to shared method
m_arg  out  ARG_W  argument to shared method (registered)
m_busy  in  1  method busy
m_return  in  RET_W  method return value, valid when m_busy falls
arb_busy  out  1  high in any state except IDLE
grant_idx  out  clog2(N_CLIENTS)  index of current/last granted client

Behaviour:
- Reset (reset=0, async): state=IDLE, all outputs 0, rr pointer = N_CLIENTS-1 (client 0 wins first), timeout counter 0.
- All outputs registered.
- IDLE:
  - if any cl_req bit set, pick first set bit searching from ptr+1 modulo N_CLIENTS.
  - Latch grant_idx, m_arg <= cl_arg slice, ptr <= grant, m_req <= 1, counter <= 0, go ISSUE.
  - m_req is high the cycle after cl_req is first seen.
- ISSUE:
  - hold m_req=1 until m_busy=1 is sampled, then m_req <= 0, go RUN.
- RUN:
  - wait for m_busy=0, then cl_ret <= m_return, cl_err <= 0, go DONE.
- DONE:
  - cl_done[grant_idx]=1 for exactly one cycle, then IDLE.
  - cl_err is cleared to 0 on leaving DONE.
- Minimum call overhead: 1 cycle IDLE->ISSUE + callee cycles + 1 cycle DONE. No back-to-back grant in the DONE cycle.
- Timeout:
  - counter increments each cycle in ISSUE/RUN.
  - At TIMEOUT-1: m_req <= 0, cl_ret <= 0, cl_err <= 1, go DONE.
  - Counter saturates; it does not wrap.
- Client rules:
  - A request dropped before grant is never serviced.
  - cl_req changes after grant are ignored; the done pulse still occurs.
  - A client must deassert cl_req in the cycle after cl_done, otherwise it is re-eligible, but only after all other requesters (pointer has advanced past it).
- Simultaneous requests: strict rotation. With all N asserting continuously, the grant order is 0,1,...,N-1,0...
- m_busy already high when entering ISSUE: accepted immediately (treated as callee start).
- Reset mid-call: immediate abort, no done pulse, m_req low; the callee must be reset by the same reset.

Decomposition:
- Package method_call_pkg: state enum {IDLE, ISSUE, RUN, DONE}, index width function clog2, timeout counter width constant.
- One sub-module: method_call_rr_select. Combinational round-robin picker with inputs req vector and ptr, outputs valid and idx.
- FSM, registers and timeout live in the top.

Test Plan:
1. Single client 2 requests with arg=0x0000_0005, callee model busy for 6 cycles returning arg*3 -> m_arg=5, cl_done[2] one pulse, cl_ret=0x0F, cl_err=0, arb_busy low afterwards.
2. All 4 clients request at once, args 10,20,30,40, callee returns arg+1 -> completions in order 0,1,2,3 with cl_ret 11,21,31,41; m_req never asserted during DONE.
3. Client 1 holds cl_req continuously and client 3 requests once -> grant sequence 1,3,1,1; client 3 not starved.
4. Callee never raises m_busy, TIMEOUT=16 -> cl_done pulse 16 cycles after ISSUE entry, cl_err=1, cl_ret=0, m_req low; the next request is served normally.
5. Assert reset=0 mid-RUN -> all outputs 0 asynchronously, no cl_done. After release, client 0 is granted first again.
6. Client 0 drops cl_req while client 2 is being served -> client 0 is never granted; only the client 2 done pulse occurs.

Source files
------------

// File: rtl/method_call_pkg.sv
// Shared types and helpers for the method call arbiter.
package method_call_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Call age counter width; wide enough for any int-sized TIMEOUT.
  localparam int TMO_CNT_W = 32;

  // Index width for a vector of n entries, never below one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/method_call_rr_select.sv
// Round-robin picker: first requester strictly after ptr, wrapping modulo N.
module method_call_rr_select
  import method_call_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand_idx;

  // Scan from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    valid    = 1'b0;
    idx      = '0;
    cand_idx = '0;
    for (int off = N; off >= 1; off--) begin
      cand_idx = IW'((int'(ptr) + off) % N);
      if (req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/method_call_arbiter.sv
// Shares one method unit between N_CLIENTS callers: round-robin grant,
// call issue, busy tracking, result return and timeout abort.
module method_call_arbiter
  import method_call_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int ARG_W     = 32,
  parameter int RET_W     = 32,
  parameter int TIMEOUT   = 10000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_CLIENTS-1:0]          cl_req,
  input  logic [N_CLIENTS*ARG_W-1:0]    cl_arg,
  output logic [N_CLIENTS-1:0]          cl_done,
  output logic [RET_W-1:0]              cl_ret,
  output logic                          cl_err,
  output logic                          m_req,
  output logic [ARG_W-1:0]              m_arg,
  input  logic                          m_busy,
  input  logic [RET_W-1:0]              m_return,
  output logic                          arb_busy,
  output logic [clog2(N_CLIENTS)-1:0]   grant_idx
);

  localparam int IDX_W = clog2(N_CLIENTS);
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic                   m_req_q, m_req_d;
  logic [ARG_W-1:0]       m_arg_q, m_arg_d;
  logic [N_CLIENTS-1:0]   cl_done_q, cl_done_d;
  logic [RET_W-1:0]       cl_ret_q, cl_ret_d;
  logic                   cl_err_q, cl_err_d;
  logic                   arb_busy_q, arb_busy_d;
  logic [TMO_CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_CNT_W-1:0]   cnt_inc;
  logic                   timed_out;
  logic                   sel_valid;
  logic [IDX_W-1:0]       sel_idx;

  method_call_rr_select #(
    .N  (N_CLIENTS),
    .IW (IDX_W)
  ) u_rr_select (
    .req   (cl_req),
    .ptr   (ptr_q),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  // Next-state and next-output logic for the call sequence.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    m_req_d    = m_req_q;
    m_arg_d    = m_arg_q;
    cl_done_d  = '0;
    cl_ret_d   = cl_ret_q;
    cl_err_d   = cl_err_q;
    cnt_d      = cnt_q;
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    timed_out  = (cnt_q == TMO_LAST);

    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          grant_d = sel_idx;
          ptr_d   = sel_idx;
          m_arg_d = cl_arg[int'(sel_idx)*ARG_W +: ARG_W];
          m_req_d = 1'b1;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE, RUN: begin
        if (timed_out) begin
          m_req_d   = 1'b0;
          cl_ret_d  = '0;
          cl_err_d  = 1'b1;
          cl_done_d = N_CLIENTS'(1) << grant_q;
          state_d   = DONE;
        end else if (state_q == ISSUE) begin
          cnt_d = cnt_inc;
          if (m_busy) begin
            m_req_d = 1'b0;
            state_d = RUN;
          end
        end else if (!m_busy) begin
          cl_ret_d  = m_return;
          cl_err_d  = 1'b0;
          cl_done_d = N_CLIENTS'(1) << grant_q;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        cl_err_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    arb_busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any call in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= IDX_W'(N_CLIENTS - 1);
      grant_q    <= '0;
      m_req_q    <= 1'b0;
      m_arg_q    <= '0;
      cl_done_q  <= '0;
      cl_ret_q   <= '0;
      cl_err_q   <= 1'b0;
      arb_busy_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      m_req_q    <= m_req_d;
      m_arg_q    <= m_arg_d;
      cl_done_q  <= cl_done_d;
      cl_ret_q   <= cl_ret_d;
      cl_err_q   <= cl_err_d;
      arb_busy_q <= arb_busy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign cl_done   = cl_done_q;
  assign cl_ret    = cl_ret_q;
  assign cl_err    = cl_err_q;
  assign m_req     = m_req_q;
  assign m_arg     = m_arg_q;
  assign arb_busy  = arb_busy_q;
  assign grant_idx = grant_q;

endmodule
